// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle control FSM for the RV32I datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) and drives the shared
// memory port (req/ready), ALU operand muxes, register-file write and PC update.
// Illegal opcodes park the FSM in TRAP until reset.
// Optional retired-instruction counter: define RISCV_CTRL_PERF_EN.
module riscv_multicycle_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [XLEN-1:0]  instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_ifetch,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  // S_FETCH_WAIT is an internal FETCH variant that keeps an issued fetch
  // request alive after run drops; it reports as FETCH on the state port.
  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEM        = 3'd3,
    S_WB         = 3'd4,
    S_TRAP       = 3'd5,
    S_FETCH_WAIT = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;

  logic is_op, is_op_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc;

  // Only the opcode field is consumed here; the rest goes to other blocks.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[XLEN-1:7];

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opcode_legal = 1'b1;
      default:                               opcode_legal = 1'b0;
    endcase
  endfunction

  // Classify the latched opcode.
  always_comb begin
    is_op     = (opcode_q == OPC_OP);
    is_op_imm = (opcode_q == OPC_OP_IMM);
    is_load   = (opcode_q == OPC_LOAD);
    is_store  = (opcode_q == OPC_STORE);
    is_branch = (opcode_q == OPC_BRANCH);
    is_jal    = (opcode_q == OPC_JAL);
    is_jalr   = (opcode_q == OPC_JALR);
    is_lui    = (opcode_q == OPC_LUI);
    is_auipc  = (opcode_q == OPC_AUIPC);
  end

  // State and opcode latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state and output decode; all outputs forced low while rst is high.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    alu_a_sel  = A_RS1;
    alu_b_sel  = B_RS2;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    trap       = 1'b0;

    if (!rst) begin
      // The ALU is combinational with no result register, so the operand
      // selection is held through MEM and WB to keep address/target stable.
      if (state_q inside {S_EXECUTE, S_MEM, S_WB}) begin
        if (is_op) begin
          alu_a_sel = A_RS1;
          alu_b_sel = B_RS2;
        end else if (is_lui) begin
          alu_a_sel = A_ZERO;
          alu_b_sel = B_IMM;
        end else if (is_auipc || is_jal || is_branch) begin
          alu_a_sel = A_PC;
          alu_b_sel = B_IMM;
        end else begin
          alu_a_sel = A_RS1;
          alu_b_sel = B_IMM;
        end
      end

      case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_req    = 1'b1;
            mem_ifetch = 1'b1;
            if (mem_ready) begin
              ir_we   = 1'b1;
              state_d = S_DECODE;
            end else begin
              state_d = S_FETCH_WAIT;
            end
          end
        end
        S_FETCH_WAIT: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          opcode_d = instr[6:0];
          state_d  = opcode_legal(instr[6:0]) ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken;
            state_d = S_FETCH;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ready) begin
            if (is_store) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = is_jal || is_jalr;
          if (is_load)                wb_sel = WB_MEM;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          else                        wb_sel = WB_ALU;
          state_d = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Report the architectural state code.
  always_comb begin
    state = (state_q == S_FETCH_WAIT) ? 3'd0 : 3'(state_q);
  end

`ifdef RISCV_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Every pc_we pulse completes exactly one instruction; TRAP never pulses.
  always_comb begin
    retired_d = retired_q;
    if (pc_we) retired_d = retired_q + CNT_W'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: per-instruction expected
// cycle schedules built from the opcode table, randomized handshakes.
module tb_riscv_multicycle_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [XLEN-1:0]  instr;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_sel;
  logic [1:0]       alu_a_sel, alu_b_sel, wb_sel;
  logic             rf_we, trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  riscv_multicycle_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ifetch(mem_ifetch),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, ifetch, irwe, pcwe, pcsel;
    logic [1:0] a, b;
    logic       rfwe;
    logic [1:0] wb;
    logic       trap;
  } rec_t;

  typedef struct {
    rec_t exp;
    logic rdy;
    logic run_v;
    logic bt;
    logic chk_ab;
  } step_t;

  step_t       exp_q[$];
  int unsigned model_retired = 0;

  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rec_t act_rec();
    rec_t r;
    r = '{st: state, req: mem_req, we: mem_we, ifetch: mem_ifetch, irwe: ir_we,
          pcwe: pc_we, pcsel: pc_sel, a: alu_a_sel, b: alu_b_sel, rfwe: rf_we,
          wb: wb_sel, trap: trap};
    return r;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic void push(input rec_t r, input logic rdy, input logic run_v,
                               input logic bt, input logic chk_ab);
    step_t s;
    s.exp = r; s.rdy = rdy; s.run_v = run_v; s.bt = bt; s.chk_ab = chk_ab;
    exp_q.push_back(s);
  endfunction

  // Expected per-cycle behaviour of one instruction, from the opcode table:
  // fetch takes wf wait cycles, data access wm wait cycles.
  function automatic void build(input logic [31:0] ins, input int unsigned wf,
                                input int unsigned wm, input logic bt,
                                input logic drop);
    rec_t z, r;
    logic [6:0] op;
    logic ld, stq, br, jmp;
    z  = '0;
    op = ins[6:0];
    for (int unsigned i = 0; i <= wf; i++) begin
      r = z; r.req = 1'b1; r.ifetch = 1'b1; r.irwe = (i == wf);
      push(r, (i == wf), !(drop && i > 0), rbit(), 1'b0);
    end
    r = z; r.st = 3'd1;
    push(r, rbit(), rbit(), rbit(), 1'b0);
    if (!is_legal(op)) begin
      for (int i = 0; i < 20; i++) begin
        r = z; r.st = 3'd5; r.trap = 1'b1;
        push(r, rbit(), rbit(), rbit(), 1'b0);
      end
      return;
    end
    ld  = (op == 7'h03);
    stq = (op == 7'h23);
    br  = (op == 7'h63);
    jmp = (op == 7'h6F) || (op == 7'h67);
    r = z; r.st = 3'd2;
    case (op)
      7'h33:               begin r.a = 2'd0; r.b = 2'd0; end
      7'h37:               begin r.a = 2'd2; r.b = 2'd1; end
      7'h17, 7'h6F, 7'h63: begin r.a = 2'd1; r.b = 2'd1; end
      default:             begin r.a = 2'd0; r.b = 2'd1; end
    endcase
    if (br) begin
      r.pcwe = 1'b1; r.pcsel = bt;
      push(r, rbit(), rbit(), bt, 1'b1);
      model_retired++;
      return;
    end
    push(r, rbit(), rbit(), rbit(), 1'b1);
    if (ld || stq) begin
      for (int unsigned i = 0; i <= wm; i++) begin
        r = z; r.st = 3'd3; r.req = 1'b1; r.we = stq;
        r.pcwe = stq && (i == wm);
        push(r, (i == wm), rbit(), rbit(), 1'b0);
      end
      if (stq) begin
        model_retired++;
        return;
      end
    end
    r = z; r.st = 3'd4; r.rfwe = 1'b1; r.pcwe = 1'b1; r.pcsel = jmp;
    r.wb = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
    push(r, rbit(), rbit(), rbit(), 1'b0);
    model_retired++;
  endfunction

  function automatic logic [CNT_W-1:0] exp_retired();
`ifdef RISCV_CTRL_PERF_EN
    return CNT_W'(model_retired);
`else
    return '0;
`endif
  endfunction

  // Plays the expected schedule (at most nmax cycles) and compares each cycle.
  task automatic drive(input logic [31:0] ins, input string name, input int nmax);
    step_t s;
    rec_t  a;
    int    cyc = 0;
    instr = ins;
    while (exp_q.size() > 0 && cyc < nmax) begin
      s = exp_q.pop_front();
      @(negedge clk);
      run = s.run_v; mem_ready = s.rdy; branch_taken = s.bt;
      #1;
      a = act_rec();
      if (!s.chk_ab) begin a.a = s.exp.a; a.b = s.exp.b; end
      checks++;
      if (a !== s.exp) begin
        errors++;
        $display("FAIL %s cyc%0d outputs got=%h want=%h (state got %0d want %0d)",
                 name, cyc, a, s.exp, a.st, s.exp.st);
      end
      cyc++;
    end
    if (exp_q.size() == 0) begin
      @(posedge clk); #1;
      checks++;
      if (retired !== exp_retired()) begin
        errors++;
        $display("FAIL %s retired got=%0d want=%0d", name, retired, exp_retired());
      end
    end
    exp_q.delete();
  endtask

  function automatic logic [31:0] rand_instr(input logic [6:0] op);
    logic [31:0] v;
    v = $urandom;
    v[6:0] = op;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; instr = '0;
    #1;
    checks++;
    if (act_rec() !== rec_t'(0) || retired !== '0) begin
      errors++;
      $display("FAIL reset outputs got=%h retired=%0d want=0", act_rec(), retired);
    end
    repeat (2) @(negedge clk);
    run = 1'b0; rst = 1'b0; model_retired = 0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release state=%0d mem_req=%b want 0/0", state, mem_req);
    end
  endtask

  task automatic test_alu();
    build(32'h00500093, 0, 0, 1'b0, 1'b0);
    drive(32'h00500093, "addi", 1000);
    foreach (legal_ops[i]) begin
      logic [31:0] v;
      if (legal_ops[i] inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h67}) begin
        v = rand_instr(legal_ops[i]);
        build(v, $urandom_range(0, 2), 0, 1'b0, 1'b0);
        drive(v, "alu_class", 1000);
      end
    end
  endtask

  task automatic test_load();
    build(32'h0000A103, 0, 3, 1'b0, 1'b0);
    drive(32'h0000A103, "lw_wait3", 1000);
  endtask

  task automatic test_store();
    build(32'h0020A023, 0, 0, 1'b0, 1'b0);
    drive(32'h0020A023, "sw_zero_wait", 1000);
    build(32'h0020A023, 1, 2, 1'b0, 1'b0);
    drive(32'h0020A023, "sw_wait", 1000);
  endtask

  task automatic test_branch();
    build(32'h00208463, 0, 0, 1'b1, 1'b0);
    drive(32'h00208463, "beq_taken", 1000);
    build(32'h00208463, 0, 0, 1'b0, 1'b0);
    drive(32'h00208463, "beq_not_taken", 1000);
  endtask

  task automatic test_jal();
    build(32'h008000EF, 0, 0, 1'b0, 1'b0);
    drive(32'h008000EF, "jal", 1000);
  endtask

  task automatic test_run_gating();
    repeat (4) begin
      @(negedge clk);
      run = 1'b0; mem_ready = rbit(); branch_taken = rbit();
      #1;
      checks++;
      if (state !== 3'd0 || mem_req !== 1'b0 || ir_we !== 1'b0) begin
        errors++;
        $display("FAIL run_low state=%0d mem_req=%b ir_we=%b want 0/0/0",
                 state, mem_req, ir_we);
      end
    end
    build(32'h00500093, 3, 0, 1'b0, 1'b1);
    drive(32'h00500093, "run_drop_fetch", 1000);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] v;
      v = rand_instr(legal_ops[$urandom_range(0, 8)]);
      build(v, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), rbit());
      drive(v, "random_seq", 1000);
    end
  endtask

  task automatic test_trap();
    logic [31:0] v;
    build(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    drive(32'hFFFFFFFF, "illegal_ff", 1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || trap !== 1'b0 || retired !== '0) begin
      errors++;
      $display("FAIL trap_reset state=%0d trap=%b retired=%0d want 0/0/0",
               state, trap, retired);
    end
    @(negedge clk);
    rst = 1'b0; model_retired = 0;
    do v = $urandom; while (is_legal(v[6:0]));
    build(v, 0, 0, 1'b0, 1'b0);
    drive(v, "illegal_rand", 1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_retired = 0;
  endtask

  task automatic test_reset_mid_mem();
    build(32'h0020A023, 0, 5, 1'b0, 1'b0);
    drive(32'h0020A023, "sw_before_reset", 5);
    rst = 1'b1; run = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_mem mem_req=%b state=%0d want 0/0", mem_req, state);
    end
    @(negedge clk);
    rst = 1'b0; model_retired = 0;
    repeat (4) begin
      @(negedge clk);
      mem_ready = rbit();
      #1;
      checks++;
      if (mem_req !== 1'b0 || state !== 3'd0) begin
        errors++;
        $display("FAIL post_reset_idle mem_req=%b state=%0d want 0/0", mem_req, state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_run_gating();
    test_back_to_back();
    test_trap();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
